apb_rr_master: RTL and testbench
================================

Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB slave port among NUM_REQ local requesters.
- Arbitrates and latches the winning request, then sequences the APB SETUP and ACCESS phases.
- The attached slave registers read data one cycle after ACCESS, so for reads the master captures prdata in the cycle after ACCESS and returns it to the winner with a one-cycle done pulse.
- Sits between on-chip initiators (BFM drivers, config engines) and apb_slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- addrWidth, 32, APB address width.
- dataWidth, 32, APB data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester transfer request; held high until done.
- req_write  input  NUM_REQ  per-requester direction: 1 = write, 0 = read.
- req_addr  input  NUM_REQ*addrWidth  packed addresses; requester i uses slice i.
- req_wdata  input  NUM_REQ*dataWidth  packed write data; requester i uses slice i.
- grant  output  NUM_REQ  one-hot owner of the current transfer; 0 when idle.
- done  output  NUM_REQ  one-cycle pulse to the owner at transfer completion.
- rdata  output  dataWidth  read data; valid in the done cycle of a read.
- busy  output  1  high in any state other than IDLE.
- paddr  output  addrWidth  APB address.
- pwrite  output  1  APB direction.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwdata  output  dataWidth  APB write data.
- prdata  input  dataWidth  APB read data from the slave.

Behaviour:
- Reset (async, rst=1): state=IDLE; grant, done, rdata, busy, paddr, pwrite, psel, penable, pwdata all 0; round-robin pointer = 0.
- FSM states: IDLE, SETUP, ACCESS, RDCAP.
- IDLE:
  - If any req bit is set, pick the first set bit at or above ptr, wrapping modulo NUM_REQ.
  - Latch that requester's addr, wdata and write into paddr, pwdata, pwrite; set grant to its one-hot bit; go to SETUP.
  - If no req bit is set, remain in IDLE with all outputs 0.
- SETUP (1 cycle): psel=1, penable=0; go to ACCESS.
- ACCESS (1 cycle): psel=1, penable=1.
  - Write: done[owner] pulses this cycle; go to IDLE.
  - Read: go to RDCAP.
- RDCAP (1 cycle): psel=0, penable=0; rdata<=prdata captured at the end of this cycle.
  - done[owner] asserts in the following IDLE cycle, together with valid rdata.
  - Read done is therefore registered: done rises on the edge that leaves RDCAP.
- Completion:
  - On completion, ptr = owner+1, wrapping at NUM_REQ-1 -> 0.
  - grant clears when the FSM enters IDLE.
- Latency, req seen in IDLE to done:
  - Write: 3 cycles (IDLE, SETUP, ACCESS); done is in ACCESS.
  - Read: 4 cycles; done is in the IDLE cycle after RDCAP.
- Arbitration occurs only in IDLE; every transfer returns to IDLE for at least one cycle before the next arbitration.
- Hold rules:
  - paddr, pwrite and pwdata are stable from SETUP through ACCESS (and RDCAP), using latched values.
  - Later changes to req_* are ignored until the next arbitration.
- Requester drops req mid-transfer: the transfer still completes and done still pulses; the requester ignores it.
- The owner's req still high on the done cycle is seen as a new request.
  - Requesters must deassert req on the done cycle.
  - Requester i may not re-request for one cycle. Round-robin serves others first when they are pending.
- rdata holds its last read value until the next read capture; it is not cleared by writes.
- Reset mid-transfer: immediate return to IDLE with psel and penable low. No done is issued for the aborted transfer.
- All NUM_REQ requesting simultaneously from reset: service order is 0, 1, 2, 3, 0, ...

Decomposition:
- definesPkg gains an apb_mst_st_e enum (IDLE, SETUP, ACCESS, RDCAP) and a default NUM_REQ constant.
- The round-robin picker is one natural sub-module: rr_arbiter.
  - Inputs: req vector and ptr.
  - Outputs: one-hot gnt and a valid flag. Purely combinational.
  - The FSM and datapath stay in apb_rr_master.

Test Plan:
- Reset then single write: req[1]=1, addr=0x10, wdata=0xA5A5_0001.
  - psel rises 1 cycle later; penable the cycle after; done[1] in the ACCESS cycle.
  - Slave mem[0x10]=0xA5A5_0001.
- Read-back: req[1] read addr=0x10 -> rdata=0xA5A5_0001 with done[1] exactly 4 cycles after req is seen; psel low in RDCAP.
- Contention: req=4'b1111, all writes, addr=i, data=0x100+i, each requester dropping req on its done.
  - grant order 0, 1, 2, 3; each write takes 3 cycles including IDLE.
  - Reads of 0..3 return 0x100..0x103.
- Fairness: req[0] held continuously (re-raised after 1 cycle) with req[2] pending -> grant alternates 0, 2, 0, 2; req[2] is never starved.
- Reset mid-read: assert rst during ACCESS.
  - psel, penable, grant and done go 0 immediately; no done pulse.
  - After release, a new req[3] read is serviced normally.
- Stability: change req_addr[0] from 0x20 to 0x30 during SETUP -> paddr stays 0x20 through ACCESS; the write lands at 0x20.

Source files
------------

// File: rtl/apb_rr_master_pkg.sv
// Shared types and helpers for the round-robin APB master.
package apb_rr_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RDCAP  = 2'd3
  } apb_mst_st_e;

  localparam int DEF_NUM_REQ = 4;
  // Pointer/index width covers the full 2..8 requester range.
  localparam int IDX_W = 3;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx, input int n);
    return (int'(idx) >= n - 1) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/apb_rr_master_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter
  import apb_rr_master_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  logic [NUM_REQ-1:0] hi_s;
  logic [NUM_REQ-1:0] pick_s;

  // Prefer requests at or above ptr; otherwise fall back to the lowest request.
  always_comb begin
    hi_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_s[i] = req[i] & (IDX_W'(i) >= ptr);
    end
    pick_s = (|hi_s) ? hi_s : req;
    gnt    = pick_s & (~pick_s + NUM_REQ'(1));
    valid  = |req;
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one slave port among NUM_REQ requesters.
module apb_rr_master
  import apb_rr_master_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*addrWidth-1:0]   req_addr,
  input  logic [NUM_REQ*dataWidth-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic [dataWidth-1:0]           rdata,
  output logic                           busy,
  output logic [addrWidth-1:0]           paddr,
  output logic                           pwrite,
  output logic                           psel,
  output logic                           penable,
  output logic [dataWidth-1:0]           pwdata,
  input  logic [dataWidth-1:0]           prdata
);

  apb_mst_st_e state_r, state_nxt_s;

  logic [NUM_REQ-1:0]   grant_r, done_r, grant_nxt_s, done_nxt_s;
  logic [dataWidth-1:0] rdata_r, pwdata_r, rdata_nxt_s, pwdata_nxt_s;
  logic [addrWidth-1:0] paddr_r, paddr_nxt_s;
  logic                 busy_r, pwrite_r, psel_r, penable_r;
  logic                 busy_nxt_s, pwrite_nxt_s, psel_nxt_s, penable_nxt_s;
  logic [IDX_W-1:0]     ptr_r, ptr_nxt_s, owner_s;

  logic [NUM_REQ-1:0]   arb_gnt_s;
  logic                 arb_valid_s;
  logic [addrWidth-1:0] sel_addr_s;
  logic [dataWidth-1:0] sel_wdata_s;
  logic                 sel_write_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr_r),
    .gnt   (arb_gnt_s),
    .valid (arb_valid_s)
  );

  // Winner's request fields and current owner index, selected by one-hot OR.
  always_comb begin
    sel_addr_s  = {addrWidth{1'b0}};
    sel_wdata_s = {dataWidth{1'b0}};
    sel_write_s = 1'b0;
    owner_s     = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s  = sel_addr_s  | (arb_gnt_s[i] ? req_addr[i*addrWidth +: addrWidth]  : {addrWidth{1'b0}});
      sel_wdata_s = sel_wdata_s | (arb_gnt_s[i] ? req_wdata[i*dataWidth +: dataWidth] : {dataWidth{1'b0}});
      sel_write_s = sel_write_s | (arb_gnt_s[i] & req_write[i]);
      owner_s     = owner_s     | (grant_r[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE:    state_nxt_s = arb_valid_s ? SETUP : IDLE;
      SETUP:   state_nxt_s = ACCESS;
      ACCESS:  state_nxt_s = pwrite_r ? IDLE : RDCAP;
      RDCAP:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output/datapath next values; outputs are registered so they follow the state they belong to.
  always_comb begin
    grant_nxt_s   = grant_r;
    done_nxt_s    = {NUM_REQ{1'b0}};
    rdata_nxt_s   = rdata_r;
    paddr_nxt_s   = paddr_r;
    pwrite_nxt_s  = pwrite_r;
    pwdata_nxt_s  = pwdata_r;
    ptr_nxt_s     = ptr_r;
    case (state_r)
      IDLE: begin
        grant_nxt_s  = arb_valid_s ? arb_gnt_s   : {NUM_REQ{1'b0}};
        paddr_nxt_s  = arb_valid_s ? sel_addr_s  : {addrWidth{1'b0}};
        pwdata_nxt_s = arb_valid_s ? sel_wdata_s : {dataWidth{1'b0}};
        pwrite_nxt_s = arb_valid_s & sel_write_s;
      end
      SETUP: begin
        // Write completion is signalled in ACCESS itself.
        done_nxt_s = pwrite_r ? grant_r : {NUM_REQ{1'b0}};
      end
      ACCESS: begin
        if (pwrite_r) begin
          grant_nxt_s  = {NUM_REQ{1'b0}};
          paddr_nxt_s  = {addrWidth{1'b0}};
          pwdata_nxt_s = {dataWidth{1'b0}};
          pwrite_nxt_s = 1'b0;
          ptr_nxt_s    = next_ptr(owner_s, NUM_REQ);
        end else begin
          grant_nxt_s  = grant_r;
        end
      end
      RDCAP: begin
        rdata_nxt_s  = prdata;
        done_nxt_s   = grant_r;
        grant_nxt_s  = {NUM_REQ{1'b0}};
        paddr_nxt_s  = {addrWidth{1'b0}};
        pwdata_nxt_s = {dataWidth{1'b0}};
        pwrite_nxt_s = 1'b0;
        ptr_nxt_s    = next_ptr(owner_s, NUM_REQ);
      end
      default: begin
        grant_nxt_s  = {NUM_REQ{1'b0}};
      end
    endcase
    psel_nxt_s    = (state_nxt_s == SETUP) || (state_nxt_s == ACCESS);
    penable_nxt_s = (state_nxt_s == ACCESS);
    busy_nxt_s    = (state_nxt_s != IDLE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_r   <= {NUM_REQ{1'b0}};
      done_r    <= {NUM_REQ{1'b0}};
      rdata_r   <= {dataWidth{1'b0}};
      paddr_r   <= {addrWidth{1'b0}};
      pwdata_r  <= {dataWidth{1'b0}};
      pwrite_r  <= 1'b0;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      busy_r    <= 1'b0;
      ptr_r     <= {IDX_W{1'b0}};
    end else begin
      grant_r   <= grant_nxt_s;
      done_r    <= done_nxt_s;
      rdata_r   <= rdata_nxt_s;
      paddr_r   <= paddr_nxt_s;
      pwdata_r  <= pwdata_nxt_s;
      pwrite_r  <= pwrite_nxt_s;
      psel_r    <= psel_nxt_s;
      penable_r <= penable_nxt_s;
      busy_r    <= busy_nxt_s;
      ptr_r     <= ptr_nxt_s;
    end
  end

  assign grant   = grant_r;
  assign done    = done_r;
  assign rdata   = rdata_r;
  assign busy    = busy_r;
  assign paddr   = paddr_r;
  assign pwrite  = pwrite_r;
  assign psel    = psel_r;
  assign penable = penable_r;
  assign pwdata  = pwdata_r;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with a small registered-read APB slave model.
module tb_apb_rr_master;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req, req_write, grant, done;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     rdata, pwdata, prdata;
  logic [AW-1:0]     paddr;
  logic              busy, pwrite, psel, penable;

  logic [DW-1:0]     mem [0:255];
  int                n_cmp = 0;
  int                n_err = 0;

  apb_rr_master #(.NUM_REQ(N), .addrWidth(AW), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rdata(rdata), .busy(busy), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: writes in ACCESS, read data registered one cycle after ACCESS.
  always @(posedge clk) begin
    if (psel && penable) begin
      if (pwrite) mem[paddr[7:0]] <= pwdata;
      else        prdata <= mem[paddr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_write[i]           = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req[i]                 = 1'b1;
  endtask

  task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d);
    logic [N-1:0] oh;
    oh = N'(1) << i;
    set_req(i, 1'b1, a, d);
    tick();
    chk("wr_setup_grant", grant, oh);
    chk("wr_setup_psel", {psel, penable}, 2'b10);
    chk("wr_setup_paddr", paddr, a);
    tick();
    chk("wr_access_pen", {psel, penable}, 2'b11);
    chk("wr_access_done", done, oh);
    chk("wr_access_pwdata", pwdata, d);
    req[i] = 1'b0;
    tick();
    chk("wr_idle_grant", grant, {N{1'b0}});
    chk("wr_idle_done", done, {N{1'b0}});
    chk("wr_mem", mem[a[7:0]], d);
  endtask

  task automatic do_read(input int i, input logic [31:0] a, input logic [31:0] exp);
    logic [N-1:0] oh;
    oh = N'(1) << i;
    set_req(i, 1'b0, a, 32'h0);
    tick();
    chk("rd_setup_grant", grant, oh);
    tick();
    chk("rd_access", {psel, penable, done}, {2'b11, {N{1'b0}}});
    tick();
    chk("rd_rdcap", {psel, penable, done, grant}, {2'b00, {N{1'b0}}, oh});
    tick();
    chk("rd_done", done, oh);
    chk("rd_rdata", rdata, exp);
    chk("rd_idle_grant", {busy, grant}, {1'b0, {N{1'b0}}});
    req[i] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    prdata    = 32'h0;
    rst       = 1'b1;
    req       = {N{1'b0}};
    req_write = {N{1'b0}};
    req_addr  = {N*AW{1'b0}};
    req_wdata = {N*DW{1'b0}};
    tick();
    tick();
    chk("rst_outs", {grant, done, busy, psel, penable, pwrite}, 14'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Single write then read-back.
    do_write(1, 32'h10, 32'hA5A5_0001);
    do_read(1, 32'h10, 32'hA5A5_0001);

    // Contention from a fresh reset: all four write at once.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, k, 32'h100 + k);
    for (int k = 0; k < N; k++) begin
      tick();
      chk("cont_grant", grant, N'(1) << k);
      tick();
      chk("cont_done", done, N'(1) << k);
      req[k] = 1'b0;
      tick();
      chk("cont_idle", grant, {N{1'b0}});
    end
    for (int k = 0; k < N; k++) do_read(k, k, 32'h100 + k);

    // Fairness: requester 0 keeps coming back, requester 2 must not starve.
    set_req(0, 1'b1, 32'h40, 32'h40);
    set_req(2, 1'b1, 32'h42, 32'h42);
    for (int t = 0; t < 4; t++) begin
      int w;
      w = (t % 2 == 0) ? 0 : 2;
      tick();
      chk("fair_grant", grant, N'(1) << w);
      tick();
      chk("fair_done", done, N'(1) << w);
      req[w] = 1'b0;
      tick();
      req[w] = 1'b1;
    end
    req = {N{1'b0}};

    // Reset during ACCESS of a read.
    set_req(3, 1'b0, 32'h10, 32'h0);
    tick();
    tick();
    chk("rstmid_pre", {psel, penable}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rstmid_now", {psel, penable, grant, done, busy}, 11'h0);
    tick();
    chk("rstmid_hold", {psel, done}, 5'h0);
    rst = 1'b0;
    req = {N{1'b0}};
    tick();
    chk("rstmid_nodone", done, {N{1'b0}});
    do_read(3, 32'h10, 32'hA5A5_0001);

    // Address change after arbitration must not reach the bus.
    set_req(0, 1'b1, 32'h20, 32'hDEAD_0020);
    tick();
    chk("stab_setup", paddr, 32'h20);
    req_addr[0 +: AW] = 32'h30;
    tick();
    chk("stab_access", paddr, 32'h20);
    req[0] = 1'b0;
    tick();
    chk("stab_mem20", mem[8'h20], 32'hDEAD_0020);
    chk("stab_mem30", mem[8'h30], 32'h0);
    chk("rdata_held", rdata, 32'hA5A5_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
